// File: rtl/ro_addr_seq.sv
// Ring-buffer readout address sequencer: snapshots the write pointer on request and
// walks DEPTH-modulo addresses (any DEPTH) across NCH channel planes, one word per SPI ack.
module ro_addr_seq #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic [AW-1:0] ain,
  input  logic [AW-1:0] offset_in,
  input  logic [AW:0]   howmany_in,
  input  logic          dir_in,
  input  logic          rd_request,
  input  logic          SPI_done,
  output logic [AW-1:0] address,
  output logic [CW-1:0] channel,
  output logic          addr_valid,
  output logic          ro_done_n,
  output logic          ro_done,
  output logic          ro_abort
);

  localparam int unsigned SW      = AW + 3;
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] off_q, off_d;
  logic [AW:0]   n_q, n_d;
  logic          dir_q, dir_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] address_q, address_d;
  logic [CW-1:0] channel_q, channel_d;
  logic          addr_valid_q, addr_valid_d;
  logic          ro_done_n_q, ro_done_n_d;
  logic          ro_done_q, ro_done_d;
  logic          ro_abort_q, ro_abort_d;

  logic [SW-1:0] start_raw;
  logic [AW-1:0] start_c;
  logic [AW-1:0] step_c;

  // Start address: forward can underflow by nearly 2*DEPTH, so wrap up to twice.
  always_comb begin
    start_raw = SW'(ain) - SW'(off_q) - (dir_q ? SW'(n_q) : SW'(1));
    if (start_raw[SW-1]) start_raw = start_raw + DEPTH_S;
    if (start_raw[SW-1]) start_raw = start_raw + DEPTH_S;
    start_c = AW'(start_raw);
  end

  always_comb begin
    if (dir_q) step_c = (address_q == LAST_A) ? '0 : address_q + AW'(1);
    else       step_c = (address_q == '0) ? LAST_A : address_q - AW'(1);
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    n_d          = n_q;
    dir_d        = dir_q;
    start_d      = start_q;
    rem_d        = rem_q;
    address_d    = address_q;
    channel_d    = channel_q;
    addr_valid_d = 1'b0;
    ro_done_n_d  = 1'b0;
    ro_done_d    = 1'b0;
    ro_abort_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        address_d = '0;
        if (!rd_request) begin
          off_d = (offset_in > LAST_A) ? LAST_A : offset_in;
          n_d   = (howmany_in > DEPTH_N) ? DEPTH_N : howmany_in;
          dir_d = dir_in;
        end else if (n_q == '0) begin
          state_d   = S_DONE;
          ro_done_d = 1'b1;
        end else begin
          state_d      = S_RUN;
          start_d      = start_c;
          address_d    = start_c;
          channel_d    = '0;
          rem_d        = n_q;
          addr_valid_d = 1'b1;
          ro_done_n_d  = 1'b1;
        end
      end
      S_RUN: begin
        addr_valid_d = 1'b1;
        ro_done_n_d  = 1'b1;
        // Abort wins over a same-cycle ack.
        if (!rd_request) begin
          state_d      = S_IDLE;
          ro_abort_d   = 1'b1;
          addr_valid_d = 1'b0;
          ro_done_n_d  = 1'b0;
          address_d    = '0;
          channel_d    = '0;
          rem_d        = '0;
        end else if (SPI_done) begin
          if (rem_q > (AW+1)'(1)) begin
            rem_d     = rem_q - (AW+1)'(1);
            address_d = step_c;
          end else if (channel_q != LAST_CH) begin
            channel_d = channel_q + CW'(1);
            address_d = start_q;
            rem_d     = n_q;
          end else begin
            state_d      = S_DONE;
            ro_done_d    = 1'b1;
            addr_valid_d = 1'b0;
            ro_done_n_d  = 1'b0;
          end
        end
      end
      S_DONE: state_d = S_HOLD;
      S_HOLD: if (!rd_request) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      n_q          <= '0;
      dir_q        <= 1'b0;
      start_q      <= '0;
      rem_q        <= '0;
      address_q    <= '0;
      channel_q    <= '0;
      addr_valid_q <= 1'b0;
      ro_done_n_q  <= 1'b0;
      ro_done_q    <= 1'b0;
      ro_abort_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      n_q          <= n_d;
      dir_q        <= dir_d;
      start_q      <= start_d;
      rem_q        <= rem_d;
      address_q    <= address_d;
      channel_q    <= channel_d;
      addr_valid_q <= addr_valid_d;
      ro_done_n_q  <= ro_done_n_d;
      ro_done_q    <= ro_done_d;
      ro_abort_q   <= ro_abort_d;
    end
  end

  assign address    = address_q;
  assign channel    = channel_q;
  assign addr_valid = addr_valid_q;
  assign ro_done_n  = ro_done_n_q;
  assign ro_done    = ro_done_q;
  assign ro_abort   = ro_abort_q;

endmodule

// File: tb/tb_ro_addr_seq.sv
// Directed bench for ro_addr_seq with a non-power-of-two depth and four channel planes.
module tb_ro_addr_seq;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 3000;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CW    = 2;

  logic          sysclk = 1'b0;
  logic          rst;
  logic [AW-1:0] ain;
  logic [AW-1:0] offset_in;
  logic [AW:0]   howmany_in;
  logic          dir_in;
  logic          rd_request;
  logic          SPI_done;
  logic [AW-1:0] address;
  logic [CW-1:0] channel;
  logic          addr_valid;
  logic          ro_done_n;
  logic          ro_done;
  logic          ro_abort;

  int total = 0;
  int bad   = 0;
  int exp_addr_q[$];
  int exp_ch_q[$];

  always #5 sysclk = ~sysclk;

  ro_addr_seq #(.AW(AW), .DEPTH(DEPTH), .NCH(NCH), .CW(CW)) dut (
    .sysclk(sysclk), .rst(rst), .ain(ain), .offset_in(offset_in),
    .howmany_in(howmany_in), .dir_in(dir_in), .rd_request(rd_request),
    .SPI_done(SPI_done), .address(address), .channel(channel),
    .addr_valid(addr_valid), .ro_done_n(ro_done_n), .ro_done(ro_done),
    .ro_abort(ro_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  function automatic int wrap(input int v);
    int r;
    r = v % int'(DEPTH);
    if (r < 0) r = r + int'(DEPTH);
    return r;
  endfunction

  // One request; abort_after >= 0 drops rd_request before that ack index.
  task automatic readout(input string tag, input int a, input int off_in, input int n_in,
                         input bit d, input int abort_after, input bit abort_with_ack);
    int off, n, s, words, cur_a;
    off = (off_in > int'(DEPTH) - 1) ? int'(DEPTH) - 1 : off_in;
    n   = (n_in > int'(DEPTH)) ? int'(DEPTH) : n_in;
    ain = AW'(a); offset_in = AW'(off_in); howmany_in = (AW+1)'(n_in); dir_in = d;
    rd_request = 1'b0; SPI_done = 1'b0;
    step(); step();
    s = wrap(a - off - (d ? n : 1));
    for (int c = 0; c < int'(NCH); c++)
      for (int k = 0; k < n; k++) begin
        exp_addr_q.push_back(wrap(d ? s + k : s - k));
        exp_ch_q.push_back(c);
      end
    words = int'(NCH) * n;
    rd_request = 1'b1;
    step();
    if (n == 0) begin
      check({tag, ":n0_done"}, ro_done, 1);
      check({tag, ":n0_valid"}, addr_valid, 0);
      step();
      check({tag, ":n0_done_clr"}, ro_done, 0);
      check({tag, ":n0_valid2"}, addr_valid, 0);
    end else begin
      for (int w = 0; w < words; w++) begin
        if (w == abort_after) begin
          rd_request = 1'b0; SPI_done = abort_with_ack;
          step();
          SPI_done = 1'b0;
          check({tag, ":abort"}, ro_abort, 1);
          check({tag, ":abort_valid"}, addr_valid, 0);
          check({tag, ":abort_addr"}, address, 0);
          check({tag, ":abort_done_n"}, ro_done_n, 0);
          check({tag, ":abort_done"}, ro_done, 0);
          step();
          check({tag, ":abort_clr"}, ro_abort, 0);
          check({tag, ":idle_valid"}, addr_valid, 0);
          exp_addr_q.delete();
          exp_ch_q.delete();
          return;
        end
        cur_a = exp_addr_q.pop_front();
        check({tag, ":valid"}, addr_valid, 1);
        check({tag, ":done_n"}, ro_done_n, 1);
        check({tag, ":addr"}, address, cur_a);
        check({tag, ":chan"}, channel, exp_ch_q.pop_front());
        ain = AW'($urandom_range(0, DEPTH - 1));
        repeat ($urandom_range(0, 1)) begin
          step();
          check({tag, ":hold_addr"}, address, cur_a);
        end
        SPI_done = 1'b1;
        step();
        SPI_done = 1'b0;
      end
      check({tag, ":done"}, ro_done, 1);
      check({tag, ":end_valid"}, addr_valid, 0);
      check({tag, ":end_done_n"}, ro_done_n, 0);
      step();
      check({tag, ":done_pulse"}, ro_done, 0);
      repeat (3) begin
        step();
        check({tag, ":no_restart"}, addr_valid, 0);
        check({tag, ":no_redone"}, ro_done, 0);
      end
    end
    rd_request = 1'b0;
    step(); step();
    check({tag, ":sb_empty"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; ain = '0; offset_in = '0; howmany_in = '0; dir_in = 1'b0;
    rd_request = 1'b0; SPI_done = 1'b0;
    step(); step();
    check("rst_addr", address, 0);
    check("rst_chan", channel, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_done_n", ro_done_n, 0);
    check("rst_done", ro_done, 0);
    check("rst_abort", ro_abort, 0);
    rst = 1'b0;
    step();

    readout("bwd_basic",   100, 0,    3,    1'b0, -1, 1'b0);
    readout("bwd_wrap",    1,   2,    4,    1'b0, -1, 1'b0);
    readout("fwd_same",    1,   2,    4,    1'b1, -1, 1'b0);
    readout("fwd_wrap",    2,   0,    4,    1'b1, -1, 1'b0);
    readout("bwd_zero",    1,   0,    3,    1'b0, -1, 1'b0);
    readout("nch4",        10,  0,    2,    1'b0, -1, 1'b0);
    readout("off_clamp",   5,   4000, 2,    1'b0, -1, 1'b0);
    readout("n_clamp",     7,   0,    4095, 1'b1, 3,  1'b0);
    readout("abort",       50,  0,    5,    1'b0, 1,  1'b0);
    readout("abort_ack",   50,  0,    5,    1'b0, 2,  1'b1);
    readout("n_zero",      50,  0,    0,    1'b0, -1, 1'b0);

    // Reset in the middle of a readout.
    ain = 12'd10; offset_in = '0; howmany_in = 13'd5; dir_in = 1'b0;
    step(); step();
    rd_request = 1'b1;
    step();
    check("mid_valid", addr_valid, 1);
    check("mid_addr", address, 9);
    SPI_done = 1'b1; step(); SPI_done = 1'b0;
    check("mid_addr2", address, 8);
    rst = 1'b1; rd_request = 1'b0;
    step();
    check("mrst_addr", address, 0);
    check("mrst_chan", channel, 0);
    check("mrst_valid", addr_valid, 0);
    check("mrst_done_n", ro_done_n, 0);
    check("mrst_done", ro_done, 0);
    check("mrst_abort", ro_abort, 0);
    rst = 1'b0;
    step();
    check("mrst_abort2", ro_abort, 0);
    check("mrst_valid2", addr_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
